// File: rtl/ISO14443A_pkg.sv
// Shared ISO14443A definitions: PICC->PCD bit-sequence encoding and parity helpers.
package ISO14443A_pkg;

    typedef enum logic [1:0] {
        PICC_SEQ_SOC    = 2'd0,
        PICC_SEQ_LOGIC0 = 2'd1,
        PICC_SEQ_LOGIC1 = 2'd2,
        PICC_SEQ_EOC    = 2'd3
    } PICCBitSequence;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    function automatic PICCBitSequence data_seq(input logic b);
        return b ? PICC_SEQ_LOGIC1 : PICC_SEQ_LOGIC0;
    endfunction

endpackage

// File: rtl/frame_encode.sv
// PICC response frame encoder: bytes in, SOC / data bits (LSB first) / odd parity / EOC out.
module frame_encode
    import ISO14443A_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic [2:0] in_data_bits,
    input  logic       in_last,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] out_seq,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       underflow,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_SOC,
        SEND_DATA,
        SEND_PARITY,
        WAIT_BYTE,
        SEND_EOC
    } state_t;

    state_t         state, state_n;
    logic [7:0]     data_r, data_n;
    logic [3:0]     nbits_r, nbits_n;
    logic           last_r, last_n;
    logic           parity_r, parity_n;
    logic [2:0]     bit_idx, bit_idx_n;
    PICCBitSequence seq_r, seq_n;
    logic           valid_r, valid_n;
    logic           underflow_r, underflow_n;
    logic           done_r, done_n;

    logic           xfer;
    logic           latch;
    logic [3:0]     nbits_in;

    assign xfer     = valid_r & out_ready;
    assign nbits_in = (in_data_bits == 3'd0) ? 4'd8 : {1'b0, in_data_bits};

    assign in_ready = (state == IDLE) | (state == WAIT_BYTE) |
                      ((state == SEND_PARITY) & out_ready & ~last_r);

    assign out_seq   = seq_r;
    assign out_valid = valid_r;
    assign underflow = underflow_r;
    assign done      = done_r;

    always_comb begin
        state_n     = state;
        data_n      = data_r;
        nbits_n     = nbits_r;
        last_n      = last_r;
        parity_n    = parity_r;
        bit_idx_n   = bit_idx;
        seq_n       = seq_r;
        valid_n     = valid_r;
        underflow_n = 1'b0;
        done_n      = 1'b0;
        latch       = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    latch   = 1'b1;
                    seq_n   = PICC_SEQ_SOC;
                    valid_n = 1'b1;
                    state_n = SEND_SOC;
                end
            end

            SEND_SOC: begin
                if (xfer) begin
                    seq_n     = data_seq(data_r[0]);
                    bit_idx_n = '0;
                    state_n   = SEND_DATA;
                end
            end

            SEND_DATA: begin
                if (xfer) begin
                    if ({1'b0, bit_idx} < (nbits_r - 4'd1)) begin
                        bit_idx_n = bit_idx + 3'd1;
                        seq_n     = data_seq(data_r[bit_idx + 3'd1]);
                    end else if (nbits_r == 4'd8) begin
                        seq_n   = data_seq(parity_r);
                        state_n = SEND_PARITY;
                    end else begin
                        seq_n   = PICC_SEQ_EOC;
                        state_n = SEND_EOC;
                    end
                end
            end

            SEND_PARITY: begin
                // Next byte chains straight into data so there is no gap after parity.
                if (xfer) begin
                    if (last_r) begin
                        seq_n   = PICC_SEQ_EOC;
                        state_n = SEND_EOC;
                    end else if (in_valid) begin
                        latch     = 1'b1;
                        seq_n     = data_seq(in_data[0]);
                        bit_idx_n = '0;
                        state_n   = SEND_DATA;
                    end else begin
                        valid_n = 1'b0;
                        state_n = WAIT_BYTE;
                    end
                end
            end

            WAIT_BYTE: begin
                if (in_valid) begin
                    latch     = 1'b1;
                    seq_n     = data_seq(in_data[0]);
                    valid_n   = 1'b1;
                    bit_idx_n = '0;
                    state_n   = SEND_DATA;
                end else if (out_ready) begin
                    underflow_n = 1'b1;
                    seq_n       = PICC_SEQ_EOC;
                    valid_n     = 1'b1;
                    state_n     = SEND_EOC;
                end
            end

            SEND_EOC: begin
                if (xfer) begin
                    valid_n = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end

            default: begin
                valid_n = 1'b0;
                state_n = IDLE;
            end
        endcase

        // A partial byte always closes the frame.
        if (latch) begin
            data_n   = in_data;
            nbits_n  = nbits_in;
            last_n   = in_last | (nbits_in != 4'd8);
            parity_n = odd_parity(in_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            data_r      <= '0;
            nbits_r     <= '0;
            last_r      <= 1'b0;
            parity_r    <= 1'b0;
            bit_idx     <= '0;
            seq_r       <= PICC_SEQ_EOC;
            valid_r     <= 1'b0;
            underflow_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state       <= state_n;
            data_r      <= data_n;
            nbits_r     <= nbits_n;
            last_r      <= last_n;
            parity_r    <= parity_n;
            bit_idx     <= bit_idx_n;
            seq_r       <= seq_n;
            valid_r     <= valid_n;
            underflow_r <= underflow_n;
            done_r      <= done_n;
        end
    end

endmodule

// File: tb/tb_frame_encode.sv
// Directed self-checking bench for frame_encode (sequence codes: SOC=0, L0=1, L1=2, EOC=3).
module tb_frame_encode;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic [2:0] in_data_bits;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] out_seq;
    logic       out_valid;
    logic       out_ready;
    logic       underflow;
    logic       done;

    frame_encode dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_data_bits (in_data_bits),
        .in_last      (in_last),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_seq      (out_seq),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .underflow    (underflow),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [2:0] b;
        logic       l;
    } byte_t;

    byte_t      bq[$];
    logic [1:0] got[$];
    int         n_done, n_unf, unf_at, rdy_busy, gaps, viol;
    bit         timed_out;
    int         vectors = 0;
    int         miscompares = 0;

    // Drives queued bytes and out_ready, records transfers; stops on done, stop_after transfers or budget.
    task automatic run(input int budget, input bit stall, input int stop_after);
        int         stall_left = 0;
        logic [1:0] hold = '0;
        bit         prev_ov = 0, prev_xfer = 0, started = 0;
        logic       ov;
        logic [1:0] os;
        got.delete();
        n_done = 0; n_unf = 0; unf_at = -1; rdy_busy = 0; gaps = 0; viol = 0;
        timed_out = 1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            ov = out_valid;
            os = out_seq;
            if (stall && ov && (prev_xfer || !prev_ov)) begin
                stall_left = 10;
                hold = os;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                if (ov !== 1'b1 || os !== hold) viol++;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (bq.size() > 0) begin
                in_valid     = 1'b1;
                in_data      = bq[0].d;
                in_data_bits = bq[0].b;
                in_last      = bq[0].l;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (done === 1'b1) n_done++;
            if (underflow === 1'b1) begin
                n_unf++;
                unf_at = got.size();
            end
            if (ov) started = 1;
            if (started && !ov && n_done == 0) gaps++;
            if (ov && in_ready) rdy_busy++;
            prev_xfer = ov && out_ready;
            prev_ov   = ov;
            if (prev_xfer) got.push_back(os);
            if (in_valid && in_ready) void'(bq.pop_front());
            if (done === 1'b1 || (stop_after > 0 && got.size() >= stop_after)) begin
                timed_out = 0;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_data_bits = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        vectors++; if (out_seq !== 2'd3) begin miscompares++; $display("FAIL reset_out_seq got=%0d exp=3", out_seq); end
        vectors++; if (underflow !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL reset_pulses got=%b%b exp=00", underflow, done); end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single_byte;
        logic [1:0] exp [11] = '{0, 2, 2, 1, 1, 2, 1, 1, 2, 2, 3};
        int extra_done = 0;
        bq.push_back(byte_t'{8'h93, 3'd0, 1'b1});
        run(100, 0, 0);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL single_timeout got=timeout exp=done"); end
        vectors++; if (got.size() != 11) begin miscompares++; $display("FAIL single_len got=%0d exp=11", got.size()); end
        for (int i = 0; i < 11; i++) begin
            if (i < got.size()) begin
                vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL single_seq[%0d] got=%0d exp=%0d", i, got[i], exp[i]); end
            end
        end
        vectors++; if (rdy_busy != 0) begin miscompares++; $display("FAIL single_in_ready_busy got=%0d exp=0", rdy_busy); end
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
        end
        vectors++; if (n_done + extra_done != 1) begin miscompares++; $display("FAIL single_done_count got=%0d exp=1", n_done + extra_done); end
        vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL single_idle got=rdy%b/vld%b exp=rdy1/vld0", in_ready, out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp [20] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3};
        bq.push_back(byte_t'{8'h00, 3'd0, 1'b0});
        bq.push_back(byte_t'{8'hFF, 3'd0, 1'b1});
        run(100, 0, 0);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL b2b_timeout got=timeout exp=done"); end
        vectors++; if (got.size() != 20) begin miscompares++; $display("FAIL b2b_len got=%0d exp=20", got.size()); end
        for (int i = 0; i < 20; i++) begin
            if (i < got.size()) begin
                vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL b2b_seq[%0d] got=%0d exp=%0d", i, got[i], exp[i]); end
            end
        end
        vectors++; if (gaps != 0) begin miscompares++; $display("FAIL b2b_gaps got=%0d exp=0", gaps); end
        vectors++; if (rdy_busy != 1) begin miscompares++; $display("FAIL b2b_in_ready_busy got=%0d exp=1", rdy_busy); end
        vectors++; if (n_done != 1) begin miscompares++; $display("FAIL b2b_done got=%0d exp=1", n_done); end
    endtask

    task automatic test_partial;
        logic [1:0] exp [5] = '{0, 2, 1, 2, 3};
        @(negedge clk);
        bq.push_back(byte_t'{8'h05, 3'd3, 1'b0});
        run(100, 0, 0);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL partial_timeout got=timeout exp=done"); end
        vectors++; if (got.size() != 5) begin miscompares++; $display("FAIL partial_len got=%0d exp=5", got.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < got.size()) begin
                vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL partial_seq[%0d] got=%0d exp=%0d", i, got[i], exp[i]); end
            end
        end
        vectors++; if (n_done != 1) begin miscompares++; $display("FAIL partial_done got=%0d exp=1", n_done); end
    endtask

    task automatic test_underflow;
        logic [1:0] exp [11] = '{0, 2, 1, 2, 1, 1, 2, 1, 2, 2, 3};
        @(negedge clk);
        bq.push_back(byte_t'{8'hA5, 3'd0, 1'b0});
        run(100, 0, 0);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL underflow_timeout got=timeout exp=done"); end
        vectors++; if (got.size() != 11) begin miscompares++; $display("FAIL underflow_len got=%0d exp=11", got.size()); end
        for (int i = 0; i < 11; i++) begin
            if (i < got.size()) begin
                vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL underflow_seq[%0d] got=%0d exp=%0d", i, got[i], exp[i]); end
            end
        end
        vectors++; if (n_unf != 1) begin miscompares++; $display("FAIL underflow_count got=%0d exp=1", n_unf); end
        vectors++; if (unf_at != 10) begin miscompares++; $display("FAIL underflow_position got=%0d exp=10", unf_at); end
        vectors++; if (gaps != 1) begin miscompares++; $display("FAIL underflow_gap got=%0d exp=1", gaps); end
        vectors++; if (n_done != 1) begin miscompares++; $display("FAIL underflow_done got=%0d exp=1", n_done); end
    endtask

    task automatic test_back_pressure;
        logic [1:0] exp [14] = '{0, 2, 2, 1, 1, 2, 1, 1, 2, 2, 2, 1, 2, 3};
        @(negedge clk);
        bq.push_back(byte_t'{8'h93, 3'd0, 1'b0});
        bq.push_back(byte_t'{8'h05, 3'd3, 1'b0});
        run(400, 1, 0);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL stall_timeout got=timeout exp=done"); end
        vectors++; if (got.size() != 14) begin miscompares++; $display("FAIL stall_len got=%0d exp=14", got.size()); end
        for (int i = 0; i < 14; i++) begin
            if (i < got.size()) begin
                vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL stall_seq[%0d] got=%0d exp=%0d", i, got[i], exp[i]); end
            end
        end
        vectors++; if (viol != 0) begin miscompares++; $display("FAIL stall_stability got=%0d exp=0", viol); end
        vectors++; if (n_done != 1) begin miscompares++; $display("FAIL stall_done got=%0d exp=1", n_done); end
    endtask

    task automatic test_reset_mid_frame;
        logic [1:0] exp [11] = '{0, 2, 1, 1, 1, 1, 1, 1, 1, 1, 3};
        int bad = 0;
        @(negedge clk);
        bq.push_back(byte_t'{8'h3C, 3'd0, 1'b1});
        run(100, 0, 5);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL midrst_timeout got=timeout exp=5xfers"); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_async_valid got=%b exp=0", out_valid); end
        vectors++; if (out_seq !== 2'd3) begin miscompares++; $display("FAIL midrst_out_seq got=%0d exp=3", out_seq); end
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (done !== 1'b0 || out_valid !== 1'b0) bad++;
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL midrst_no_eoc got=%0d exp=0", bad); end
        bq.push_back(byte_t'{8'h01, 3'd0, 1'b1});
        run(100, 0, 0);
        vectors++; if (got.size() != 11) begin miscompares++; $display("FAIL midrst_len got=%0d exp=11", got.size()); end
        for (int i = 0; i < 11; i++) begin
            if (i < got.size()) begin
                vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL midrst_seq[%0d] got=%0d exp=%0d", i, got[i], exp[i]); end
            end
        end
        vectors++; if (n_done != 1) begin miscompares++; $display("FAIL midrst_done got=%0d exp=1", n_done); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_partial();
        test_underflow();
        test_back_pressure();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
